// File: rtl/trdb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : trdb_pkg
//  Description : Shared trace-stream constants and the unaligner FSM states.
//  Revision    : 1.0 - initial release
// ============================================================================
package trdb_pkg;

    localparam int XLEN       = 32;
    localparam int LENW       = 7;
    localparam int PACKET_LEN = 127;

    typedef logic [1:0] trdb_unalign_state_t;

    localparam trdb_unalign_state_t UNALIGN_HDR  = 2'd0;
    localparam trdb_unalign_state_t UNALIGN_PAD  = 2'd1;
    localparam trdb_unalign_state_t UNALIGN_PAY  = 2'd2;
    localparam trdb_unalign_state_t UNALIGN_EMIT = 2'd3;

    // Bits left in the current word once a pad header has been consumed.
    function automatic int pad_need(input int off, input int xlen);
        return (xlen - off) % xlen;
    endfunction

endpackage
`default_nettype wire

// File: rtl/trdb_bit_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : trdb_bit_fifo
//  Description : Bit-granular buffer: append whole words, consume n bits.
//  Revision    : 1.0 - initial release
// ============================================================================
module trdb_bit_fifo #(
    parameter int XLEN  = 32,
    parameter int BUFW  = 159,
    parameter int PEEKW = 127,
    parameter int CNTW  = $clog2(BUFW + 1),
    parameter int OFFW  = (XLEN > 1) ? $clog2(XLEN) : 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic [XLEN-1:0]  word_i,
    input  logic             push_i,
    output logic             push_ready_o,
    input  logic             pop_i,
    input  logic [CNTW-1:0]  pop_n_i,
    output logic [PEEKW-1:0] peek_o,
    output logic [CNTW-1:0]  cnt_o,
    output logic [OFFW-1:0]  off_o
);

    logic [BUFW-1:0] r_buf;
    logic [CNTW-1:0] r_cnt;
    logic [OFFW-1:0] r_off;

    logic [CNTW-1:0] w_pop_n;
    logic [CNTW-1:0] w_cnt_left;
    logic [BUFW-1:0] w_shifted;
    logic [BUFW-1:0] w_word_ext;
    logic            w_push;

    assign push_ready_o = (r_cnt <= CNTW'(BUFW - XLEN)) && !flush_i;
    assign w_push       = push_i && push_ready_o;
    assign w_pop_n      = pop_i ? pop_n_i : '0;

    // Bits above cnt are always zero, so the new word can simply be OR-ed in
    // at the post-consume fill level.
    assign w_shifted  = r_buf >> w_pop_n;
    assign w_cnt_left = r_cnt - w_pop_n;
    assign w_word_ext = {{(BUFW - XLEN){1'b0}}, word_i} << w_cnt_left;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_buf <= '0;
            r_cnt <= '0;
            r_off <= '0;
        end else if (flush_i) begin
            r_buf <= '0;
            r_cnt <= '0;
            r_off <= '0;
        end else begin
            r_buf <= w_push ? (w_shifted | w_word_ext) : w_shifted;
            r_cnt <= w_push ? (w_cnt_left + CNTW'(XLEN)) : w_cnt_left;
            r_off <= OFFW'((int'(r_off) + int'(w_pop_n)) % XLEN);
        end
    end

    assign peek_o = r_buf[PEEKW-1:0];
    assign cnt_o  = r_cnt;
    assign off_o  = r_off;

    a_cnt_bound : assert property (@(posedge clk_i) disable iff (!rst_ni)
        r_cnt <= CNTW'(BUFW));
    a_pop_avail : assert property (@(posedge clk_i) disable iff (!rst_ni)
        pop_i |-> (pop_n_i <= r_cnt));

endmodule
`default_nettype wire

// File: rtl/trdb_stream_unalign.sv
`default_nettype none
// ============================================================================
//  Module      : trdb_stream_unalign
//  Description : Splits the packed trace word stream back into length/bits
//                packets.
//  Revision    : 1.0 - initial release
// ============================================================================
module trdb_stream_unalign #(
    parameter int XLEN       = trdb_pkg::XLEN,
    parameter int LENW       = trdb_pkg::LENW,
    parameter int PACKET_LEN = trdb_pkg::PACKET_LEN
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic [XLEN-1:0]       word_i,
    input  logic                  word_valid_i,
    output logic                  word_ready_o,
    output logic [PACKET_LEN-1:0] packet_bits_o,
    output logic [LENW-1:0]       packet_len_o,
    output logic                  packet_valid_o,
    input  logic                  packet_ready_i,
    output logic [15:0]           packet_cnt_o,
    output logic [15:0]           pad_cnt_o
);
    import trdb_pkg::*;

    localparam int BUFW = PACKET_LEN + XLEN;
    localparam int CNTW = $clog2(BUFW + 1);
    localparam int OFFW = (XLEN > 1) ? $clog2(XLEN) : 1;

    if (PACKET_LEN != (2 ** LENW) - 1) begin : g_bad_packet_len
        $error("trdb_stream_unalign: PACKET_LEN must equal 2**LENW-1");
    end

    trdb_unalign_state_t   r_state;
    logic [LENW-1:0]       r_len;
    logic [PACKET_LEN-1:0] r_bits;
    logic [LENW-1:0]       r_plen;
    logic                  r_valid;
    logic [15:0]           r_pkt_cnt;
    logic [15:0]           r_pad_cnt;

    logic [PACKET_LEN-1:0] w_peek;
    logic [PACKET_LEN-1:0] w_mask;
    logic [CNTW-1:0]       w_cnt;
    logic [CNTW-1:0]       w_need;
    logic [CNTW-1:0]       w_pop_n;
    logic [OFFW-1:0]       w_off;
    logic [LENW-1:0]       w_hdr;
    logic                  w_pop;
    logic                  w_hdr_rdy;
    logic                  w_pad_done;
    logic                  w_pay_rdy;

    trdb_bit_fifo #(
        .XLEN  (XLEN),
        .BUFW  (BUFW),
        .PEEKW (PACKET_LEN),
        .CNTW  (CNTW),
        .OFFW  (OFFW)
    ) u_bit_fifo (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .flush_i      (flush_i),
        .word_i       (word_i),
        .push_i       (word_valid_i),
        .push_ready_o (word_ready_o),
        .pop_i        (w_pop),
        .pop_n_i      (w_pop_n),
        .peek_o       (w_peek),
        .cnt_o        (w_cnt),
        .off_o        (w_off)
    );

    assign w_hdr      = w_peek[LENW-1:0];
    assign w_need     = CNTW'(pad_need(int'(w_off), XLEN));
    assign w_hdr_rdy  = w_cnt >= CNTW'(LENW);
    assign w_pad_done = (w_need == '0) || (w_cnt >= w_need);
    assign w_pay_rdy  = w_cnt >= CNTW'(r_len);

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < PACKET_LEN; i++) begin
            w_mask[i] = (i < int'(r_len));
        end
    end

    always_comb begin
        w_pop   = 1'b0;
        w_pop_n = '0;
        case (r_state)
            UNALIGN_HDR: begin
                if (w_hdr_rdy) begin
                    w_pop   = 1'b1;
                    w_pop_n = CNTW'(LENW);
                end
            end
            UNALIGN_PAD: begin
                if ((w_need != '0) && (w_cnt >= w_need)) begin
                    w_pop   = 1'b1;
                    w_pop_n = w_need;
                end
            end
            UNALIGN_PAY: begin
                if (w_pay_rdy) begin
                    w_pop   = 1'b1;
                    w_pop_n = CNTW'(r_len);
                end
            end
            default: begin
                w_pop   = 1'b0;
                w_pop_n = '0;
            end
        endcase
    end

    // Flush beats any handshake or decode step in the same cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= UNALIGN_HDR;
            r_len     <= '0;
            r_bits    <= '0;
            r_plen    <= '0;
            r_valid   <= 1'b0;
            r_pkt_cnt <= '0;
            r_pad_cnt <= '0;
        end else if (flush_i) begin
            r_state <= UNALIGN_HDR;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                UNALIGN_HDR: begin
                    if (w_hdr_rdy) begin
                        r_len <= w_hdr;
                        if (w_hdr == '0) begin
                            r_pad_cnt <= r_pad_cnt + 16'd1;
                            r_state   <= UNALIGN_PAD;
                        end else begin
                            r_state <= UNALIGN_PAY;
                        end
                    end
                end
                UNALIGN_PAD: begin
                    if (w_pad_done) begin
                        r_state <= UNALIGN_HDR;
                    end
                end
                UNALIGN_PAY: begin
                    if (w_pay_rdy) begin
                        r_bits  <= w_peek & w_mask;
                        r_plen  <= r_len;
                        r_valid <= 1'b1;
                        r_state <= UNALIGN_EMIT;
                    end
                end
                UNALIGN_EMIT: begin
                    if (packet_ready_i) begin
                        r_valid   <= 1'b0;
                        r_pkt_cnt <= r_pkt_cnt + 16'd1;
                        r_state   <= UNALIGN_HDR;
                    end
                end
                default: r_state <= UNALIGN_HDR;
            endcase
        end
    end

    assign packet_bits_o  = r_bits;
    assign packet_len_o   = r_plen;
    assign packet_valid_o = r_valid;
    assign packet_cnt_o   = r_pkt_cnt;
    assign pad_cnt_o      = r_pad_cnt;

    a_valid_hold : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (packet_valid_o && !packet_ready_i && !flush_i) |=> packet_valid_o);

endmodule
`default_nettype wire

// File: tb/tb_trdb_stream_unalign.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_trdb_stream_unalign
//  Description : Self-checking bench: reference packer model plus scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_trdb_stream_unalign;

    localparam int XLEN = 32;
    localparam int LENW = 7;
    localparam int PLEN = 127;

    typedef struct {
        logic [PLEN-1:0] bits;
        int              len;
    } pkt_t;

    logic            clk_i = 1'b0;
    logic            rst_ni = 1'b0;
    logic            flush_i = 1'b0;
    logic [XLEN-1:0] word_i = '0;
    logic            word_valid_i = 1'b0;
    logic            word_ready_o;
    logic [PLEN-1:0] packet_bits_o;
    logic [LENW-1:0] packet_len_o;
    logic            packet_valid_o;
    logic            packet_ready_i = 1'b0;
    logic [15:0]     packet_cnt_o;
    logic [15:0]     pad_cnt_o;

    trdb_stream_unalign #(
        .XLEN       (XLEN),
        .LENW       (LENW),
        .PACKET_LEN (PLEN)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .flush_i        (flush_i),
        .word_i         (word_i),
        .word_valid_i   (word_valid_i),
        .word_ready_o   (word_ready_o),
        .packet_bits_o  (packet_bits_o),
        .packet_len_o   (packet_len_o),
        .packet_valid_o (packet_valid_o),
        .packet_ready_i (packet_ready_i),
        .packet_cnt_o   (packet_cnt_o),
        .pad_cnt_o      (pad_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    bit              bitq[$];
    logic [XLEN-1:0] q_words[$];
    pkt_t            exp_q[$];
    int              model_pads = 0;
    int              model_pcnt = 0;
    int              words_accepted = 0;
    int              rdy_mode = 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Reference packer: LSB-first bit stream, words emitted every XLEN bits.
    function automatic void push_bit(input bit b);
        logic [XLEN-1:0] w;
        bitq.push_back(b);
        if (bitq.size() == XLEN) begin
            for (int i = 0; i < XLEN; i++) w[i] = bitq[i];
            bitq.delete();
            q_words.push_back(w);
        end
    endfunction

    function automatic void add_packet(input int len, input logic [PLEN-1:0] bits);
        pkt_t p;
        p.len  = len;
        p.bits = '0;
        for (int i = 0; i < LENW; i++) push_bit(((len >> i) & 1) != 0);
        for (int i = 0; i < len; i++) begin
            push_bit(bits[i]);
            p.bits[i] = bits[i];
        end
        exp_q.push_back(p);
    endfunction

    function automatic void add_pad();
        for (int i = 0; i < LENW; i++) push_bit(1'b0);
        while (bitq.size() != 0) push_bit(1'b0);
        model_pads++;
    endfunction

    initial begin : driver
        bit acc;
        forever begin
            @(negedge clk_i);
            acc = word_valid_i && word_ready_o && rst_ni;
            @(posedge clk_i);
            #1;
            if (acc) begin
                word_valid_i = 1'b0;
                words_accepted++;
            end
            if (!word_valid_i && q_words.size() > 0 && $urandom_range(0, 9) != 0) begin
                word_i       = q_words.pop_front();
                word_valid_i = 1'b1;
            end
        end
    end

    initial begin : consumer
        forever begin
            @(posedge clk_i);
            #1;
            case (rdy_mode)
                0:       packet_ready_i = 1'b1;
                1:       packet_ready_i = 1'b0;
                default: packet_ready_i = ($urandom_range(0, 99) < 75);
            endcase
        end
    end

    initial begin : scoreboard
        logic [PLEN-1:0] pb;
        logic [LENW-1:0] pl;
        bit              hold;
        pkt_t            e;
        hold = 1'b0;
        pb   = '0;
        pl   = '0;
        forever begin
            @(negedge clk_i);
            if (!rst_ni) begin
                hold = 1'b0;
            end else begin
                if (hold) begin
                    chk("hold_valid", 128'(packet_valid_o), 128'(1));
                    chk("hold_bits", 128'(packet_bits_o), 128'(pb));
                    chk("hold_len", 128'(packet_len_o), 128'(pl));
                end
                chk("packet_cnt", 128'(packet_cnt_o), 128'(model_pcnt[15:0]));
                if (packet_valid_o && packet_ready_i && !flush_i) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_packet: got len %0d bits 0x%0h, required no packet",
                                 packet_len_o, packet_bits_o);
                    end else begin
                        e = exp_q.pop_front();
                        chk("pkt_len", 128'(packet_len_o), 128'(e.len));
                        chk("pkt_bits", 128'(packet_bits_o), 128'(e.bits));
                    end
                    model_pcnt++;
                end
                hold = packet_valid_o && !packet_ready_i && !flush_i;
                pb   = packet_bits_o;
                pl   = packet_len_o;
            end
        end
    end

    task automatic wait_accepted(input int target, input string name);
        int g = 0;
        while (words_accepted < target && g < 500) begin
            #1;
            g++;
        end
        chk(name, 128'(words_accepted >= target), 128'(1));
    endtask

    task automatic wait_drain(input int max_cycles, input string name);
        int n = 0;
        while ((q_words.size() != 0 || word_valid_i || exp_q.size() != 0) && n < max_cycles) begin
            @(negedge clk_i);
            n++;
        end
        chk(name, 128'(exp_q.size()), 128'(0));
        repeat (12) @(negedge clk_i);
        chk({name, "_pads"}, 128'(pad_cnt_o), 128'(model_pads[15:0]));
    endtask

    initial begin : main
        int              base;
        logic [127:0]    rnd;
        logic [XLEN-1:0] w;
        int              len;

        repeat (3) @(negedge clk_i);
        chk("rst_word_ready", 128'(word_ready_o), 128'(1));
        chk("rst_valid", 128'(packet_valid_o), 128'(0));
        chk("rst_bits", 128'(packet_bits_o), 128'(0));
        chk("rst_len", 128'(packet_len_o), 128'(0));
        chk("rst_pkt_cnt", 128'(packet_cnt_o), 128'(0));
        chk("rst_pad_cnt", 128'(pad_cnt_o), 128'(0));
        @(posedge clk_i);
        #1 rst_ni = 1'b1;

        // Single packet, held by the consumer to observe latency.
        add_packet(5, PLEN'(22));
        add_pad();
        add_pad();
        chk("pack_single_w0", 128'(q_words[0]), 128'(32'h00000B05));
        chk("pack_single_w1", 128'(q_words[1]), 128'(32'h00000000));
        wait_accepted(words_accepted + 1, "single_accept");
        @(negedge clk_i);
        chk("lat_cycle0", 128'(packet_valid_o), 128'(0));
        @(negedge clk_i);
        chk("lat_cycle1", 128'(packet_valid_o), 128'(0));
        @(negedge clk_i);
        chk("lat_cycle2", 128'(packet_valid_o), 128'(1));
        chk("single_bits", 128'(packet_bits_o), 128'(8'h16));
        chk("single_len", 128'(packet_len_o), 128'(5));
        rdy_mode = 0;
        wait_drain(300, "single");
        chk("single_pkt_cnt", 128'(packet_cnt_o), 128'(1));
        chk("single_pad_cnt", 128'(pad_cnt_o), 128'(2));

        // Header 40 + 40-bit payload spanning two words.
        add_packet(40, PLEN'(40'hA5DEADBEEF));
        add_pad();
        chk("pack_span_w0", 128'(q_words[0]), 128'(32'h56DF77A8));
        chk("pack_span_w1", 128'(q_words[1]), 128'(32'h000052EF));
        wait_drain(300, "span");

        // Leading pad word followed by a packet.
        q_words.push_back('0);
        model_pads++;
        add_packet(5, PLEN'(22));
        add_pad();
        wait_drain(300, "pad");

        // Backpressure with back-to-back 8-bit packets.
        base = model_pcnt;
        @(posedge clk_i);
        #1 rdy_mode = 1;
        for (int i = 0; i < 40; i++) add_packet(8, PLEN'($urandom_range(0, 255)));
        add_pad();
        repeat (20) @(negedge clk_i);
        chk("bp_word_ready", 128'(word_ready_o), 128'(0));
        chk("bp_valid", 128'(packet_valid_o), 128'(1));
        rdy_mode = 0;
        wait_drain(2000, "bp");
        chk("bp_pkt_cnt", 128'(packet_cnt_o), 128'(base + 40));

        // Flush in the middle of a 100-bit payload.
        base = model_pcnt;
        w = XLEN'($urandom);
        q_words.push_back({w[XLEN-1:LENW], 7'd100});
        q_words.push_back(XLEN'($urandom));
        wait_accepted(words_accepted + 2, "flush_accept");
        repeat (3) @(negedge clk_i);
        @(posedge clk_i);
        #1 flush_i = 1'b1;
        @(posedge clk_i);
        #1 flush_i = 1'b0;
        repeat (10) @(negedge clk_i);
        chk("flush_valid", 128'(packet_valid_o), 128'(0));
        chk("flush_pkt_cnt", 128'(packet_cnt_o), 128'(base));
        add_packet(5, PLEN'(22));
        add_pad();
        wait_drain(300, "after_flush");

        // Asynchronous reset while a packet waits in EMIT.
        @(posedge clk_i);
        #1 rdy_mode = 1;
        add_packet(5, PLEN'(22));
        add_pad();
        begin
            int g = 0;
            while (!packet_valid_o && g < 500) begin
                #1;
                g++;
            end
        end
        chk("emit_reached", 128'(packet_valid_o), 128'(1));
        #2 rst_ni = 1'b0;
        exp_q.delete();
        model_pcnt = 0;
        model_pads = 0;
        #1;
        chk("arst_valid", 128'(packet_valid_o), 128'(0));
        chk("arst_bits", 128'(packet_bits_o), 128'(0));
        chk("arst_len", 128'(packet_len_o), 128'(0));
        chk("arst_pkt_cnt", 128'(packet_cnt_o), 128'(0));
        chk("arst_pad_cnt", 128'(pad_cnt_o), 128'(0));
        chk("arst_word_ready", 128'(word_ready_o), 128'(1));
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        rdy_mode = 2;

        // Random loopback against the reference packer.
        for (int i = 0; i < 10000; i++) begin
            len = $urandom_range(1, PLEN);
            rnd = {$urandom, $urandom, $urandom, $urandom};
            add_packet(len, rnd[PLEN-1:0]);
            if ($urandom_range(0, 19) == 0) add_pad();
        end
        add_pad();
        wait_drain(70000, "loopback");
        chk("loop_pkt_cnt", 128'(packet_cnt_o), 128'(10000));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
